decode_stage_pipe: RTL

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

---
 rtl/decode_pkg.sv | 30 +++
 rtl/decode_stage_pipe_if.sv | 41 ++++
 rtl/decode_stage_pipe_reg_file_p.sv | 47 ++++
 rtl/decode_stage_pipe.sv | 136 +++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared encodings and instruction field positions for the decode stage.
package decode_pkg;

  typedef enum logic [1:0] {
    BROP_NONE     = 2'b00,
    BROP_BEQ      = 2'b01,
    BROP_BNE      = 2'b10,
    BROP_NONE_ALT = 2'b11
  } brop_e;

  typedef enum logic [1:0] {
    FWD_RF      = 2'b00,
    FWD_RESULTW = 2'b01,
    FWD_ALUOUTM = 2'b10,
    FWD_RF_ALT  = 2'b11
  } fwd_e;

  localparam int RS_MSB   = 25;
  localparam int RS_LSB   = 21;
  localparam int RT_MSB   = 20;
  localparam int RT_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int JIDX_MSB = 25;
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Bundle of fetch, hazard, write-back and ID/EX signals around the decode stage.
interface decode_stage_pipe_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       InstrF;
  logic [DATA_W-1:0] PCPlus4F;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic              RegWriteW;
  logic [4:0]        WriteRegW;
  logic [DATA_W-1:0] ResultW;
  logic [DATA_W-1:0] ALUOutM;
  logic [1:0]        ForwardAD;
  logic [1:0]        ForwardBD;
  logic [1:0]        BrOpD;
  logic              PCSrcD;
  logic [DATA_W-1:0] PCBranchD;
  logic [DATA_W-1:0] PCJumpD;
  logic [4:0]        RsD;
  logic [4:0]        RtD;
  logic [DATA_W-1:0] RD1E;
  logic [DATA_W-1:0] RD2E;
  logic [DATA_W-1:0] SignImmE;
  logic [4:0]        RsE;
  logic [4:0]        RtE;
  logic [4:0]        RdE;
  logic              ValidE;

  modport master (
    output InstrF, PCPlus4F, StallD, FlushD, FlushE, RegWriteW, WriteRegW, ResultW,
           ALUOutM, ForwardAD, ForwardBD, BrOpD,
    input  PCSrcD, PCBranchD, PCJumpD, RsD, RtD, RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE
  );

  modport slave (
    input  InstrF, PCPlus4F, StallD, FlushD, FlushE, RegWriteW, WriteRegW, ResultW,
           ALUOutM, ForwardAD, ForwardBD, BrOpD,
    output PCSrcD, PCBranchD, PCJumpD, RsD, RtD, RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE
  );
endinterface

// File: rtl/decode_stage_pipe_reg_file_p.sv
// Flop-based register file: two combinational read ports, one write port,
// r0 hard-wired to zero, optional same-cycle write-to-read bypass.
module reg_file_p #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int WR_BYPASS = 1,
  parameter int AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs_reg [NUM_REGS];
  logic [AW-1:0]     ra [2];
  logic [DATA_W-1:0] rd [2];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs_reg[wa] <= wd;
    end
  end

  assign ra[0] = ra1;
  assign ra[1] = ra2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rd[gi] = (ra[gi] == '0)                                  ? '0 :
                    ((WR_BYPASS != 0) && we && (wa == ra[gi]))       ? wd :
                                                                       regs_reg[ra[gi]];
  end

  assign rd1 = rd[0];
  assign rd2 = rd[1];

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: IF/ID register, register file, early branch resolution with
// forwarded compare operands, branch/jump target generation and ID/EX register.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int WR_BYPASS = 1,
  parameter int NUM_REGS  = 32
) (
  input  logic               CLK,
  input  logic               RST,
  decode_stage_pipe_if.slave bus
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [31:0]       instr_d_reg;
  logic [DATA_W-1:0] pc_plus4_d_reg;
  logic              valid_d_reg;

  always_ff @(posedge CLK) begin
    if (RST || bus.FlushD) begin
      instr_d_reg    <= '0;
      pc_plus4_d_reg <= '0;
      valid_d_reg    <= 1'b0;
    end else if (!bus.StallD) begin
      instr_d_reg    <= bus.InstrF;
      pc_plus4_d_reg <= bus.PCPlus4F;
      valid_d_reg    <= 1'b1;
    end
  end

  logic [4:0]        rs_d;
  logic [4:0]        rt_d;
  logic [4:0]        rd_d;
  logic [5:0]        unused_opcode;
  logic [DATA_W-1:0] sign_imm;

  assign rs_d          = instr_d_reg[RS_MSB:RS_LSB];
  assign rt_d          = instr_d_reg[RT_MSB:RT_LSB];
  assign rd_d          = instr_d_reg[RD_MSB:RD_LSB];
  assign unused_opcode = instr_d_reg[OP_MSB:OP_LSB];
  assign sign_imm      = {{(DATA_W-16){instr_d_reg[IMM_MSB]}}, instr_d_reg[IMM_MSB:IMM_LSB]};

  logic              rf_we;
  logic [DATA_W-1:0] rf_rd [2];

  // Address 0 is filtered on the full 5-bit field before truncation.
  assign rf_we = bus.RegWriteW && (bus.WriteRegW != 5'd0);

  reg_file_p #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .WR_BYPASS (WR_BYPASS)
  ) u_reg_file (
    .clk  (CLK),
    .srst (RST),
    .we   (rf_we),
    .wa   (bus.WriteRegW[AW-1:0]),
    .wd   (bus.ResultW),
    .ra1  (rs_d[AW-1:0]),
    .ra2  (rt_d[AW-1:0]),
    .rd1  (rf_rd[0]),
    .rd2  (rf_rd[1])
  );

  fwd_e              fwd_sel [2];
  logic [DATA_W-1:0] cmp_op  [2];
  logic              equal;
  logic              br_taken;

  assign fwd_sel[0] = fwd_e'(bus.ForwardAD);
  assign fwd_sel[1] = fwd_e'(bus.ForwardBD);

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign cmp_op[gi] = (fwd_sel[gi] == FWD_RESULTW) ? bus.ResultW :
                        (fwd_sel[gi] == FWD_ALUOUTM) ? bus.ALUOutM :
                                                       rf_rd[gi];
  end

  assign equal = (cmp_op[0] == cmp_op[1]);

  always_comb begin
    br_taken = 1'b0;
    case (brop_e'(bus.BrOpD))
      BROP_BEQ: br_taken = equal;
      BROP_BNE: br_taken = !equal;
      default:  br_taken = 1'b0;
    endcase
  end

  // A bubble in IF/ID must never redirect fetch.
  assign bus.PCSrcD    = br_taken && valid_d_reg;
  assign bus.PCBranchD = pc_plus4_d_reg + (sign_imm << 2);
  assign bus.PCJumpD   = {pc_plus4_d_reg[DATA_W-1:28], instr_d_reg[JIDX_MSB:0], 2'b00};
  assign bus.RsD       = rs_d;
  assign bus.RtD       = rt_d;

  logic [DATA_W-1:0] rd1_e_reg;
  logic [DATA_W-1:0] rd2_e_reg;
  logic [DATA_W-1:0] sign_imm_e_reg;
  logic [4:0]        rs_e_reg;
  logic [4:0]        rt_e_reg;
  logic [4:0]        rd_e_reg;
  logic              valid_e_reg;

  // ID/EX carries raw register values; execute applies its own forwarding.
  always_ff @(posedge CLK) begin
    if (RST || bus.FlushE) begin
      rd1_e_reg      <= '0;
      rd2_e_reg      <= '0;
      sign_imm_e_reg <= '0;
      rs_e_reg       <= '0;
      rt_e_reg       <= '0;
      rd_e_reg       <= '0;
      valid_e_reg    <= 1'b0;
    end else begin
      rd1_e_reg      <= rf_rd[0];
      rd2_e_reg      <= rf_rd[1];
      sign_imm_e_reg <= sign_imm;
      rs_e_reg       <= rs_d;
      rt_e_reg       <= rt_d;
      rd_e_reg       <= rd_d;
      valid_e_reg    <= valid_d_reg;
    end
  end

  assign bus.RD1E     = rd1_e_reg;
  assign bus.RD2E     = rd2_e_reg;
  assign bus.SignImmE = sign_imm_e_reg;
  assign bus.RsE      = rs_e_reg;
  assign bus.RtE      = rt_e_reg;
  assign bus.RdE      = rd_e_reg;
  assign bus.ValidE   = valid_e_reg;

endmodule
